// File: rtl/bomb_fuse.sv
// Bomb fuse and blast controller: arms on bomb_check, counts frames to
// detonation, pulses explode, then holds a clipped cross flame region.
// Ports: frame_clk, Reset_n (async active-low); bomb_check, bombX, bombY,
//   range, trigger_in in; explode, flame_active, flame_x0/x1/y0/y1,
//   flame_cx/cy, fuse_left, armed out (all registered).
// Macro BOMB_CHAIN_DETONATION_EN: trigger_in forces detonation in ARMED.
module bomb_fuse #(
  parameter int unsigned FUSE_FRAMES  = 120,
  parameter int unsigned FLAME_FRAMES = 30,
  parameter int unsigned TILE         = 16,
  parameter int unsigned MAX_RANGE    = 3,
  parameter int unsigned X_MAX        = 639,
  parameter int unsigned Y_MAX        = 479
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       bomb_check,
  input  logic [9:0] bombX,
  input  logic [9:0] bombY,
  input  logic [2:0] range,
  input  logic       trigger_in,
  output logic       explode,
  output logic       flame_active,
  output logic [9:0] flame_x0,
  output logic [9:0] flame_x1,
  output logic [9:0] flame_y0,
  output logic [9:0] flame_y1,
  output logic [9:0] flame_cx,
  output logic [9:0] flame_cy,
  output logic [7:0] fuse_left,
  output logic       armed
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_BLAST
  } state_t;

  state_t     state;
  logic [7:0] flame_cnt;
  logic       trig;

`ifdef BOMB_CHAIN_DETONATION_EN
  assign trig = trigger_in;
`else
  logic unused_trig;
  assign unused_trig = trigger_in;
  assign trig = 1'b0;
`endif

  logic [2:0]  rng;
  logic [10:0] len;
  logic [10:0] bx;
  logic [10:0] by;
  logic [10:0] sx;
  logic [10:0] sy;
  logic [9:0]  x0_n;
  logic [9:0]  x1_n;
  logic [9:0]  y0_n;
  logic [9:0]  y1_n;

  // Arm length in pixels; sums kept 11 bits so clipping sees the carry.
  always_comb begin
    rng = range;
    if (range == 3'd0)
      rng = 3'd1;
    else if (32'(range) > MAX_RANGE)
      rng = 3'(MAX_RANGE);
    len = 11'(rng) * 11'(TILE);
    bx  = {1'b0, bombX};
    by  = {1'b0, bombY};
    sx  = bx + len;
    sy  = by + len;
    x0_n = (bx >= len) ? 10'(bx - len) : 10'd0;
    y0_n = (by >= len) ? 10'(by - len) : 10'd0;
    x1_n = (sx > 11'(X_MAX)) ? 10'(X_MAX) : sx[9:0];
    y1_n = (sy > 11'(Y_MAX)) ? 10'(Y_MAX) : sy[9:0];
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= S_IDLE;
      flame_cnt    <= 8'd0;
      explode      <= 1'b0;
      flame_active <= 1'b0;
      flame_x0     <= 10'd0;
      flame_x1     <= 10'd0;
      flame_y0     <= 10'd0;
      flame_y1     <= 10'd0;
      flame_cx     <= 10'd0;
      flame_cy     <= 10'd0;
      fuse_left    <= 8'd0;
      armed        <= 1'b0;
    end else begin
      explode <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bomb_check) begin
            state     <= S_ARMED;
            armed     <= 1'b1;
            fuse_left <= 8'(FUSE_FRAMES);
          end
        end
        S_ARMED: begin
          // A cancelled bomb never explodes, even on its last frame.
          if (!bomb_check) begin
            state     <= S_IDLE;
            armed     <= 1'b0;
            fuse_left <= 8'd0;
          end else if (fuse_left == 8'd1 || trig) begin
            state        <= S_BLAST;
            armed        <= 1'b0;
            fuse_left    <= 8'd0;
            explode      <= 1'b1;
            flame_active <= 1'b1;
            flame_cnt    <= 8'(FLAME_FRAMES);
            flame_cx     <= bombX;
            flame_cy     <= bombY;
            flame_x0     <= x0_n;
            flame_x1     <= x1_n;
            flame_y0     <= y0_n;
            flame_y1     <= y1_n;
          end else begin
            fuse_left <= fuse_left - 8'd1;
          end
        end
        S_BLAST: begin
          if (flame_cnt == 8'd1) begin
            state        <= S_IDLE;
            flame_cnt    <= 8'd0;
            flame_active <= 1'b0;
          end else begin
            flame_cnt <= flame_cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bomb_fuse.sv
// Self-checking bench for bomb_fuse: vector table with a scoreboard
// queue, plus hand sequences for chain, cancel, re-arm and reset.
module tb_bomb_fuse;

  logic       frame_clk;
  logic       Reset_n;
  logic       bomb_check;
  logic [9:0] bombX;
  logic [9:0] bombY;
  logic [2:0] range;
  logic       trigger_in;
  logic       explode;
  logic       flame_active;
  logic [9:0] flame_x0;
  logic [9:0] flame_x1;
  logic [9:0] flame_y0;
  logic [9:0] flame_y1;
  logic [9:0] flame_cx;
  logic [9:0] flame_cy;
  logic [7:0] fuse_left;
  logic       armed;

  bomb_fuse dut (
    .frame_clk   (frame_clk),
    .Reset_n     (Reset_n),
    .bomb_check  (bomb_check),
    .bombX       (bombX),
    .bombY       (bombY),
    .range       (range),
    .trigger_in  (trigger_in),
    .explode     (explode),
    .flame_active(flame_active),
    .flame_x0    (flame_x0),
    .flame_x1    (flame_x1),
    .flame_y0    (flame_y0),
    .flame_y1    (flame_y1),
    .flame_cx    (flame_cx),
    .flame_cy    (flame_cy),
    .fuse_left   (fuse_left),
    .armed       (armed)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] r;
    logic [9:0] x0;
    logic [9:0] x1;
    logic [9:0] y0;
    logic [9:0] y1;
  } vec_t;

  vec_t tbl [6];
  vec_t sb [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic wait_explode(inout int n);
    while (!explode && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic drain(output int f);
    f = 0;
    while (flame_active && f < 300) begin
      tick();
      f++;
      if (f == 1) chk("explode_one_cycle", int'(explode), 0);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    int   n;
    int   f;
    bomb_check = 1'b1;
    bombX = v.x;
    bombY = v.y;
    range = v.r;
    sb.push_back(v);
    tick();
    chk($sformatf("v%0d_armed", idx), int'(armed), 1);
    chk($sformatf("v%0d_fuse_load", idx), int'(fuse_left), 120);
    n = 0;
    wait_explode(n);
    chk($sformatf("v%0d_fuse_len", idx), n, 120);
    chk($sformatf("v%0d_flame_on", idx), int'(flame_active), 1);
    chk($sformatf("v%0d_fuse_zero", idx), int'(fuse_left), 0);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      e = v;
    end else begin
      e = sb.pop_front();
      chk($sformatf("v%0d_x0", idx), int'(flame_x0), int'(e.x0));
      chk($sformatf("v%0d_x1", idx), int'(flame_x1), int'(e.x1));
      chk($sformatf("v%0d_y0", idx), int'(flame_y0), int'(e.y0));
      chk($sformatf("v%0d_y1", idx), int'(flame_y1), int'(e.y1));
      chk($sformatf("v%0d_cx", idx), int'(flame_cx), int'(e.x));
      chk($sformatf("v%0d_cy", idx), int'(flame_cy), int'(e.y));
    end
    bomb_check = 1'b0;
    drain(f);
    chk($sformatf("v%0d_flame_len", idx), f, 30);
    chk($sformatf("v%0d_idle", idx), int'(armed), 0);
    chk($sformatf("v%0d_hold_x0", idx), int'(flame_x0), int'(e.x0));
    chk($sformatf("v%0d_hold_y1", idx), int'(flame_y1), int'(e.y1));
  endtask

  initial begin
    int n;
    int f;
    int ex;
    int exp_edge;

    tbl[0] = '{10'd320, 10'd240, 3'd2, 10'd288, 10'd352, 10'd208, 10'd272};
    tbl[1] = '{10'd8,   10'd470, 3'd3, 10'd0,   10'd56,  10'd422, 10'd479};
    tbl[2] = '{10'd100, 10'd100, 3'd0, 10'd84,  10'd116, 10'd84,  10'd116};
    tbl[3] = '{10'd100, 10'd100, 3'd7, 10'd52,  10'd148, 10'd52,  10'd148};
    tbl[4] = '{10'd639, 10'd0,   3'd1, 10'd623, 10'd639, 10'd0,   10'd16};
    tbl[5] = '{10'd16,  10'd479, 3'd1, 10'd0,   10'd32,  10'd463, 10'd479};

    Reset_n    = 1'b0;
    bomb_check = 1'b0;
    bombX      = '0;
    bombY      = '0;
    range      = '0;
    trigger_in = 1'b0;
    #12;
    chk("rst_explode", int'(explode), 0);
    chk("rst_flame", int'(flame_active), 0);
    chk("rst_fuse", int'(fuse_left), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_x1", int'(flame_x1), 0);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    tick();
    chk("idle_no_arm", int'(armed), 0);

    for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

    // Chain detonation: trigger sampled at edge 10 of ARMED.
    bomb_check = 1'b1;
    bombX = 10'd200;
    bombY = 10'd200;
    range = 3'd1;
    tick();
    for (int k = 1; k < 10; k++) tick();
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    n = 10;
    wait_explode(n);
`ifdef BOMB_CHAIN_DETONATION_EN
    exp_edge = 10;
`else
    exp_edge = 120;
`endif
    chk("chain_edge", n, exp_edge);
    bomb_check = 1'b0;
    drain(f);
    chk("chain_flame_len", f, 30);

    // Cancel: bomb_check low at edge 50.
    bomb_check = 1'b1;
    tick();
    for (int k = 1; k < 50; k++) tick();
    chk("cancel_fuse_before", int'(fuse_left), 71);
    bomb_check = 1'b0;
    tick();
    chk("cancel_armed", int'(armed), 0);
    chk("cancel_fuse", int'(fuse_left), 0);
    ex = 0;
    for (int k = 0; k < 150; k++) begin
      if (explode) ex++;
      tick();
    end
    chk("cancel_no_explode", ex, 0);

    // bomb_check held through BLAST re-arms right after the flame.
    bomb_check = 1'b1;
    bombX = 10'd320;
    bombY = 10'd240;
    range = 3'd2;
    tick();
    n = 0;
    wait_explode(n);
    chk("rearm_fuse_len", n, 120);
    drain(f);
    chk("rearm_flame_len", f, 30);
    tick();
    chk("rearm_armed", int'(armed), 1);
    chk("rearm_fuse", int'(fuse_left), 120);
    bomb_check = 1'b0;
    tick();
    chk("rearm_cancel", int'(armed), 0);

    // Reset mid-BLAST, then a full fuse after release.
    bomb_check = 1'b1;
    tick();
    n = 0;
    wait_explode(n);
    chk("rst_pre_fuse_len", n, 120);
    for (int k = 0; k < 5; k++) tick();
    chk("rst_pre_flame", int'(flame_active), 1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("midrst_flame", int'(flame_active), 0);
    chk("midrst_explode", int'(explode), 0);
    chk("midrst_x0", int'(flame_x0), 0);
    chk("midrst_y1", int'(flame_y1), 0);
    chk("midrst_cx", int'(flame_cx), 0);
    @(negedge frame_clk);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    tick();
    chk("post_rst_armed", int'(armed), 1);
    chk("post_rst_fuse", int'(fuse_left), 120);
    n = 0;
    wait_explode(n);
    chk("post_rst_fuse_len", n, 120);
    bomb_check = 1'b0;
    drain(f);
    chk("post_rst_flame_len", f, 30);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
